// File: rtl/dmem_responder.sv
// dmem_responder: responder end of the core's data-memory port.
//
// Serves a single-cycle core: reads are combinational from the address and the
// current state, writes land on the rising clock edge. The address space holds a
// byte-writable data RAM at 0 and a 16-byte MMIO window at MMIO_BASE containing a
// console TX FIFO (valid/ready drain) and a free-running timer with a compare
// interrupt.
//
// Ports:
//   clk          clock, all state updates on the rising edge
//   rst          synchronous active-high reset (control state only, RAM kept)
//   d_mem_addr   word-aligned byte address, bits [1:0] ignored
//   d_mem_wen    byte-lane write enables, 0 = read/idle
//   d_mem_wdata  write data, already in lane position
//   d_mem_data   combinational read data
//   tx_data      head-of-FIFO byte (don't-care while tx_valid is low)
//   tx_valid     FIFO non-empty
//   tx_ready     sink accepts tx_data when tx_valid & tx_ready
//   timer_irq    level interrupt: timer_en & (mtime >= mtimecmp)
//
// MMIO map (addr[3:2]): 0 TXDATA, 1 STATUS, 2 MTIME, 3 MTIMECMP.
// STATUS: bit0 full, bit1 empty, bit2 overflow (sticky), bit3 timer_en,
//         bits[15:8] FIFO count.

module dmem_responder #(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          TX_DEPTH    = 4,
  parameter logic [31:0] MMIO_BASE   = 32'h1000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] d_mem_addr,
  input  logic [3:0]  d_mem_wen,
  input  logic [31:0] d_mem_wdata,
  output logic [31:0] d_mem_data,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        timer_irq
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int PW = $clog2(TX_DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(TX_DEPTH);

  // Byte offset within the word is meaningless on a word-aligned port.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^d_mem_addr[1:0];

  // ---------------- address decode ----------------
  logic          ram_hit;
  logic          mmio_hit;
  logic [AW-1:0] ram_idx;
  logic [1:0]    reg_sel;

  assign ram_hit  = (d_mem_addr[31:AW+2] == '0);
  assign mmio_hit = (d_mem_addr[31:4] == MMIO_BASE[31:4]);
  assign ram_idx  = d_mem_addr[AW+1:2];
  assign reg_sel  = d_mem_addr[3:2];

  // Reset wins over every same-cycle write, so all write strobes are gated by it.
  logic ram_we;
  logic wr_txdata;
  logic wr_status;
  logic wr_mtime;
  logic wr_mtimecmp;

  assign ram_we      = ram_hit & ~rst & (|d_mem_wen);
  assign wr_txdata   = mmio_hit & ~ram_hit & ~rst & (reg_sel == 2'd0) & d_mem_wen[0];
  assign wr_status   = mmio_hit & ~ram_hit & ~rst & (reg_sel == 2'd1) & d_mem_wen[0];
  assign wr_mtime    = mmio_hit & ~ram_hit & ~rst & (reg_sel == 2'd2);
  assign wr_mtimecmp = mmio_hit & ~ram_hit & ~rst & (reg_sel == 2'd3);

  // ---------------- data RAM ----------------
  logic [31:0] ram [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int n = 0; n < 4; n++) begin
        if (d_mem_wen[n]) ram[ram_idx][8*n +: 8] <= d_mem_wdata[8*n +: 8];
      end
    end
  end

  // ---------------- TX FIFO ----------------
  logic [7:0]  fifo_mem [TX_DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [PW:0]   count;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          overflow;

  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  assign tx_valid = ~empty;
  assign tx_data  = fifo_mem[rd_ptr];
  // Full is judged on the pre-edge count: a same-cycle pop does not make room.
  assign push     = wr_txdata & ~full;
  assign pop      = tx_valid & tx_ready & ~rst;

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= d_mem_wdata[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
      if (wr_status && d_mem_wdata[2]) overflow <= 1'b0;
      else if (wr_txdata && full)      overflow <= 1'b1;
    end
  end

  // ---------------- timer ----------------
  logic [31:0] mtime;
  logic [31:0] mtimecmp;
  logic [31:0] mtime_nxt;
  logic [31:0] mtimecmp_nxt;
  logic        timer_en;

  // Written lanes override the increment; unwritten lanes still count.
  always_comb begin
    mtime_nxt    = mtime + 32'd1;
    mtimecmp_nxt = mtimecmp;
    for (int n = 0; n < 4; n++) begin
      if (wr_mtime && d_mem_wen[n])    mtime_nxt[8*n +: 8]    = d_mem_wdata[8*n +: 8];
      if (wr_mtimecmp && d_mem_wen[n]) mtimecmp_nxt[8*n +: 8] = d_mem_wdata[8*n +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mtime    <= '0;
      mtimecmp <= 32'hFFFF_FFFF;
      timer_en <= 1'b0;
    end else begin
      mtime    <= mtime_nxt;
      mtimecmp <= mtimecmp_nxt;
      if (wr_status) timer_en <= d_mem_wdata[3];
    end
  end

  assign timer_irq = timer_en & (mtime >= mtimecmp);

  // ---------------- read mux ----------------
  logic [31:0] status_word;

  assign status_word = {16'h0000, 8'(count), 4'h0, timer_en, overflow, empty, full};

  always_comb begin
    d_mem_data = '0;
    if (ram_hit) begin
      d_mem_data = ram[ram_idx];
    end else if (mmio_hit) begin
      case (reg_sel)
        2'd1:    d_mem_data = status_word;
        2'd2:    d_mem_data = mtime;
        2'd3:    d_mem_data = mtimecmp;
        default: d_mem_data = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed bench for dmem_responder with default parameters
// (1024-word RAM, 4-entry TX FIFO, MMIO at 0x1000_0000).

module tb_dmem_responder;

  localparam logic [31:0] A_TX     = 32'h1000_0000;
  localparam logic [31:0] A_STATUS = 32'h1000_0004;
  localparam logic [31:0] A_MTIME  = 32'h1000_0008;
  localparam logic [31:0] A_CMP    = 32'h1000_000C;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] d_mem_addr = '0;
  logic [3:0]  d_mem_wen = '0;
  logic [31:0] d_mem_wdata = '0;
  logic [31:0] d_mem_data;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic        timer_irq;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dmem_responder dut (
    .clk        (clk),
    .rst        (rst),
    .d_mem_addr (d_mem_addr),
    .d_mem_wen  (d_mem_wen),
    .d_mem_wdata(d_mem_wdata),
    .d_mem_data (d_mem_data),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .timer_irq  (timer_irq)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [3:0] w, input logic [31:0] d);
    @(negedge clk);
    d_mem_addr  = a;
    d_mem_wen   = w;
    d_mem_wdata = d;
    @(posedge clk);
    #1;
    d_mem_wen = '0;
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    @(negedge clk);
    d_mem_addr = a;
    d_mem_wen  = '0;
    #1;
    chk(tag, d_mem_data, exp);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    d_mem_addr = A_MTIME;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mtime", d_mem_data, 32'h0);
    chk("rst_tx_valid", {31'b0, tx_valid}, 32'h0);
    chk("rst_irq", {31'b0, timer_irq}, 32'h0);
    rst = 1'b0;
    rd_chk("rst_status", A_STATUS, 32'h0000_0002);
    rd_chk("rst_mtimecmp", A_CMP, 32'hFFFF_FFFF);

    // RAM byte lanes
    wr(32'h40, 4'hF, 32'h1122_3344);
    wr(32'h40, 4'b0100, 32'h00AA_0000);
    rd_chk("ram_lane", 32'h40, 32'h11AA_3344);
    rd_chk("ram_lsb11", 32'h43, 32'h11AA_3344);
    @(negedge clk);
    d_mem_addr = 32'h40; d_mem_wen = 4'hF; d_mem_wdata = 32'h5566_7788;
    #1;
    chk("ram_old_data", d_mem_data, 32'h11AA_3344);
    @(posedge clk);
    #1;
    d_mem_wen = '0;
    chk("ram_new_data", d_mem_data, 32'h5566_7788);

    // out of range
    wr(32'h0, 4'hF, 32'h0102_0304);
    wr(32'h1000, 4'hF, 32'hDEAD_BEEF);
    rd_chk("oor_read", 32'h1000, 32'h0);
    rd_chk("oor_alias0", 32'h0, 32'h0102_0304);
    rd_chk("unmapped", 32'h2000_0000, 32'h0);

    // FIFO ordering, no bypass, overflow
    @(negedge clk);
    d_mem_addr = A_TX; d_mem_wen = 4'h1; d_mem_wdata = 32'h41;
    #1;
    chk("no_bypass", {31'b0, tx_valid}, 32'h0);
    @(posedge clk);
    #1;
    d_mem_wen = '0;
    chk("valid_after_push", {31'b0, tx_valid}, 32'h1);
    wr(A_TX, 4'h1, 32'h42);
    wr(A_TX, 4'h1, 32'h43);
    wr(A_TX, 4'h1, 32'h44);
    rd_chk("status_full", A_STATUS, 32'h0000_0401);
    wr(A_TX, 4'h1, 32'h45);
    rd_chk("status_ovf", A_STATUS, 32'h0000_0405);
    rd_chk("txdata_reads0", A_TX, 32'h0);
    @(negedge clk);
    tx_ready = 1'b1;
    #1;
    chk("drain0", {24'b0, tx_data}, 32'h41);
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      #1;
      chk("drain", {24'b0, tx_data}, 32'h41 + i);
    end
    @(negedge clk);
    #1;
    chk("drain_empty", {31'b0, tx_valid}, 32'h0);
    tx_ready = 1'b0;
    wr(A_STATUS, 4'h1, 32'h4);
    rd_chk("ovf_cleared", A_STATUS, 32'h0000_0002);

    // push and pop together at count 2
    wr(A_TX, 4'h1, 32'h50);
    wr(A_TX, 4'h1, 32'h51);
    @(negedge clk);
    d_mem_addr = A_TX; d_mem_wen = 4'h1; d_mem_wdata = 32'h52; tx_ready = 1'b1;
    @(posedge clk);
    #1;
    d_mem_wen = '0; tx_ready = 1'b0;
    rd_chk("pp_count2", A_STATUS, 32'h0000_0200);
    chk("pp_head51", {24'b0, tx_data}, 32'h51);
    @(negedge clk);
    tx_ready = 1'b1;
    @(negedge clk);
    #1;
    chk("pp_head52", {24'b0, tx_data}, 32'h52);
    @(negedge clk);
    #1;
    chk("pp_empty", {31'b0, tx_valid}, 32'h0);
    tx_ready = 1'b0;

    // timer compare
    wr(A_CMP, 4'hF, 32'd100);
    wr(A_MTIME, 4'hF, 32'd90);
    wr(A_STATUS, 4'h1, 32'h8);
    d_mem_addr = A_MTIME;
    #1;
    chk("irq_low_early", {31'b0, timer_irq}, 32'h0);
    repeat (8) @(posedge clk);
    #1;
    chk("irq_low_e9", {31'b0, timer_irq}, 32'h0);
    chk("mtime_99", d_mem_data, 32'd99);
    @(posedge clk);
    #1;
    chk("irq_high_e10", {31'b0, timer_irq}, 32'h1);
    chk("mtime_100", d_mem_data, 32'd100);
    wr(A_STATUS, 4'h1, 32'h0);
    chk("irq_off", {31'b0, timer_irq}, 32'h0);
    rd_chk("status_ten0", A_STATUS, 32'h0000_0002);
    wr(A_CMP, 4'b0010, 32'h0000_0100);
    rd_chk("cmp_lane", A_CMP, 32'h0000_0164);
    wr(A_MTIME, 4'hF, 32'hFFFF_FFFF);
    chk("mtime_max", d_mem_data, 32'hFFFF_FFFF);
    @(posedge clk);
    #1;
    chk("mtime_wrap", d_mem_data, 32'h0);
    wr(A_MTIME, 4'hF, 32'h1234_5678);
    wr(A_MTIME, 4'b0100, 32'h00AA_0000);
    chk("mtime_lane", d_mem_data, 32'h12AA_5679);

    // full with push and pop together
    wr(A_TX, 4'h1, 32'h60);
    wr(A_TX, 4'h1, 32'h61);
    wr(A_TX, 4'h1, 32'h62);
    wr(A_TX, 4'h1, 32'h63);
    rd_chk("full2", A_STATUS, 32'h0000_0401);
    @(negedge clk);
    d_mem_addr = A_TX; d_mem_wen = 4'h1; d_mem_wdata = 32'h64; tx_ready = 1'b1;
    @(posedge clk);
    #1;
    d_mem_wen = '0; tx_ready = 1'b0;
    rd_chk("full_pp", A_STATUS, 32'h0000_0304);
    chk("full_pp_head", {24'b0, tx_data}, 32'h61);

    // reset mid-operation
    wr(A_CMP, 4'hF, 32'h0);
    wr(A_STATUS, 4'h1, 32'h8);
    chk("pre_rst_irq", {31'b0, timer_irq}, 32'h1);
    rd_chk("pre_rst_status", A_STATUS, 32'h0000_030C);
    @(negedge clk);
    rst = 1'b1;
    d_mem_addr = A_MTIME; d_mem_wen = 4'hF; d_mem_wdata = 32'h55; tx_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_mtime", d_mem_data, 32'h0);
    rst = 1'b0; d_mem_wen = '0; tx_ready = 1'b0;
    chk("post_rst_valid", {31'b0, tx_valid}, 32'h0);
    chk("post_rst_irq", {31'b0, timer_irq}, 32'h0);
    @(posedge clk);
    #1;
    chk("post_rst_resume", d_mem_data, 32'h1);
    rd_chk("post_rst_status", A_STATUS, 32'h0000_0002);
    rd_chk("post_rst_cmp", A_CMP, 32'hFFFF_FFFF);
    rd_chk("post_rst_ram40", 32'h40, 32'h5566_7788);
    rd_chk("post_rst_ram0", 32'h0, 32'h0102_0304);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
